sram_image_writer: RTL and testbench

//  Loads image data into the external 16-bit SRAM that the display path reads
//  (badge, logo, pokemon and ball frames). Accepts a byte stream over valid/ready
//  (e.g. from the RS232 loader) and packs bytes big-endian into 16-bit words.

---
 rtl/sram_image_writer.sv | 158 +++++++++++++++
 tb/tb_sram_image_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_image_writer.sv
// Packs a valid/ready byte stream big-endian into 16-bit words and writes them to
// consecutive SRAM addresses. Define SRAM_WRITE_VERIFY_EN to add a readback check per word.
module sram_image_writer #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WE_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  inout  wire  [DATA_W-1:0] io_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n,
  output logic              o_bus_own,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_words_written,
  output logic              o_error
);

  // Shared cycle counter for the write pulse and the two-cycle readback.
  localparam int CNT_W = (WE_CYCLES > 2) ? $clog2(WE_CYCLES) + 1 : 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_SETUP, S_PULSE, S_HOLD, S_RB, S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remain;
  logic [ADDR_W-1:0] r_words;
  logic [DATA_W-1:0] r_word;
  logic              w_word_done;
  logic              w_last;
  logic              w_drive;

  assign w_last = (r_remain == ADDR_W'(1));

`ifdef SRAM_WRITE_VERIFY_EN
  logic r_error;
  assign w_word_done = (r_state == S_RB) && (r_cnt == CNT_W'(1));
  assign o_error     = r_error;
`else
  assign w_word_done = (r_state == S_HOLD);
  assign o_error     = 1'b0;
`endif

  assign io_sram_data    = w_drive ? r_word : {DATA_W{1'bz}};
  assign o_sram_addr     = r_addr;
  assign o_words_written = r_words;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = (i_length == '0) ? S_FIN : S_HI;
      S_HI:    if (i_byte_valid) w_state_next = S_LO;
      S_LO:    if (i_byte_valid) w_state_next = S_SETUP;
      S_SETUP: w_state_next = S_PULSE;
      S_PULSE: if (r_cnt == CNT_W'(WE_CYCLES - 1)) w_state_next = S_HOLD;
`ifdef SRAM_WRITE_VERIFY_EN
      S_HOLD:  w_state_next = S_RB;
      S_RB:    if (w_word_done) w_state_next = w_last ? S_FIN : S_HI;
`else
      S_HOLD:  w_state_next = w_last ? S_FIN : S_HI;
      S_RB:    w_state_next = S_IDLE;
`endif
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_words  <= '0;
      r_word   <= '0;
`ifdef SRAM_WRITE_VERIFY_EN
      r_error  <= 1'b0;
`endif
    end else begin
      // Counter restarts on every state change, so it measures time in PULSE and RB.
      if (w_state_next != r_state) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE && i_start) begin
        r_addr   <= i_base_addr;
        r_remain <= i_length;
        r_words  <= '0;
`ifdef SRAM_WRITE_VERIFY_EN
        r_error  <= 1'b0;
`endif
      end
      if (r_state == S_HI && i_byte_valid) r_word[DATA_W-1 -: 8] <= i_byte;
      if (r_state == S_LO && i_byte_valid) r_word[7:0] <= i_byte;
`ifdef SRAM_WRITE_VERIFY_EN
      if (w_word_done && io_sram_data != r_word) r_error <= 1'b1;
`endif
      if (w_word_done) begin
        r_addr   <= r_addr + 1'b1;
        r_words  <= r_words + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  always_comb begin
    o_byte_ready = 1'b0;
    o_sram_we_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_ce_n  = 1'b1;
    o_sram_ub_n  = 1'b1;
    o_sram_lb_n  = 1'b1;
    o_bus_own    = 1'b0;
    w_drive      = 1'b0;
    o_busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    o_done       = (r_state == S_FIN);
    case (r_state)
      S_HI, S_LO: o_byte_ready = 1'b1;
      S_SETUP, S_PULSE, S_HOLD: begin
        o_bus_own   = 1'b1;
        o_sram_ce_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_lb_n = 1'b0;
        w_drive     = 1'b1;
        o_sram_we_n = (r_state != S_PULSE);
      end
`ifdef SRAM_WRITE_VERIFY_EN
      S_RB: begin
        o_bus_own   = 1'b1;
        o_sram_ce_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_lb_n = 1'b0;
        o_sram_oe_n = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_image_writer.sv
// Directed bench for sram_image_writer: expected SRAM writes go into a queue at stimulus
// time; a negedge monitor pops and compares on each write strobe and polices bus timing.
module tb_sram_image_writer;
  localparam int AW  = 20;
  localparam int WEC = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_byte_valid;
  logic [AW-1:0] i_base_addr, i_length;
  logic [7:0]    i_byte;
  wire  [15:0]   sram_data;
  logic          o_byte_ready, o_sram_we_n, o_sram_oe_n, o_sram_ce_n;
  logic          o_sram_ub_n, o_sram_lb_n, o_bus_own, o_busy, o_done, o_error;
  logic [AW-1:0] o_sram_addr, o_words_written;

  always #5 clk = ~clk;

  sram_image_writer #(.ADDR_W(AW), .DATA_W(16), .WE_CYCLES(WEC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .io_sram_data(sram_data), .o_sram_addr(o_sram_addr),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_ce_n(o_sram_ce_n),
    .o_sram_ub_n(o_sram_ub_n), .o_sram_lb_n(o_sram_lb_n), .o_bus_own(o_bus_own),
    .o_busy(o_busy), .o_done(o_done), .o_words_written(o_words_written), .o_error(o_error)
  );

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  logic [15:0] mem [logic [AW-1:0]];
  logic [15:0] flip = 16'h0000;
  logic [15:0] rb_data = 16'h0000;

  // SRAM model answers reads combinationally from the enables.
  assign sram_data = (!o_sram_oe_n && !o_sram_ce_n) ? rb_data : 16'hzzzz;

  function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  // Monitor / scoreboard
  logic prev_we = 1'b1, prev_ce = 1'b1;
  int we_len = 0, z_viol = 0, stab_viol = 0, done_cnt = 0, ce_cnt = 0, oe_cnt = 0;
  logic [AW-1:0] cap_addr;
  logic [15:0]   cap_data;
  wr_t e;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (!o_sram_ce_n) ce_cnt++;
    if (!o_sram_oe_n) oe_cnt++;
    if (!o_bus_own && sram_data !== 16'hzzzz) z_viol++;
    if (!o_sram_ce_n && prev_ce) begin
      cap_addr = o_sram_addr;
      cap_data = sram_data;
    end else if (!o_sram_ce_n && o_sram_oe_n &&
                 (o_sram_addr !== cap_addr || sram_data !== cap_data)) begin
      stab_viol++;
    end
    if (!o_sram_we_n) begin
      if (prev_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%h@%h required=none", sram_data, o_sram_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(o_sram_addr), 32'(e.addr));
          check("wr_data", 32'(sram_data), 32'(e.data));
        end
      end
      if (!o_sram_ce_n) mem[o_sram_addr] = sram_data;
      we_len++;
    end else begin
      if (!prev_we && !i_rst) check("we_low_cycles", we_len, WEC);
      we_len = 0;
    end
    if (!o_sram_oe_n) rb_data = mem_rd(o_sram_addr) ^ flip;
    prev_we = o_sram_we_n;
    prev_ce = o_sram_ce_n;
  end

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] len);
    @(negedge clk);
    i_base_addr = base;
    i_length    = len;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bq[$], input bit rnd);
    foreach (bq[k]) begin
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        guard++;
        if (rnd && $urandom_range(0, 1) == 0) begin
          i_byte_valid = 1'b0;
          continue;
        end
        i_byte_valid = 1'b1;
        i_byte       = bq[k];
        if (o_byte_ready) acc = 1'b1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout actual=%h required=accepted", bq[k]);
      end
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(o_done), 32'd1);
    @(negedge clk);
  endtask

  int d0, c0, n;
  logic [7:0] bq[$];

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0;
    i_base_addr = '0; i_length = '0; i_byte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n}, 5'b11111);
    check("rst_flags", {o_byte_ready, o_bus_own, o_busy, o_done, o_error}, 5'b00000);
    check("rst_addr_words", {o_sram_addr, o_words_written}, '0);
    check("rst_data_z", 32'(sram_data === 16'hzzzz), 32'd1);
    i_rst = 1'b0;

    // T1/T2: two words from 0x00100
    exp_q.push_back('{20'h00100, 16'hA1B2});
    exp_q.push_back('{20'h00101, 16'hC3D4});
    d0 = done_cnt;
    start_job(20'h00100, 20'd2);
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_bytes(bq, 1'b0);
    wait_done();
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_words", 32'(o_words_written), 32'd2);
    check("t1_mem0", 32'(mem_rd(20'h00100)), 32'hA1B2);
    check("t1_mem1", 32'(mem_rd(20'h00101)), 32'hC3D4);
    check("t1_idle", {o_busy, o_bus_own, o_error}, 3'b000);

    // T3: zero-length job
    c0 = ce_cnt; d0 = done_cnt;
    start_job(20'h00050, 20'd0);
    n = 0;
    while (!o_done && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("t3_done", 32'(o_done), 32'd1);
    @(negedge clk);
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_no_ce", ce_cnt - c0, 0);
    check("t3_words", 32'(o_words_written), 32'd0);

    // T4: address wrap
    exp_q.push_back('{20'hFFFFF, 16'h1122});
    exp_q.push_back('{20'h00000, 16'h3344});
    start_job(20'hFFFFF, 20'd2);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(bq, 1'b0);
    wait_done();
    check("t4_mem_wrap", 32'(mem_rd(20'h00000)), 32'h3344);
    check("t4_words", 32'(o_words_written), 32'd2);

    // T5: random valid gaps plus an ignored start while busy
    exp_q.push_back('{20'h00200, 16'hA1B2});
    exp_q.push_back('{20'h00201, 16'hC3D4});
    start_job(20'h00200, 20'd2);
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    fork
      send_bytes(bq, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("t5_busy_mid", 32'(o_busy), 32'd1);
        i_base_addr = 20'h12345;
        i_length    = 20'd5;
        i_start     = 1'b1;
        @(negedge clk);
        i_start     = 1'b0;
      end
    join
    wait_done();
    check("t5_mem0", 32'(mem_rd(20'h00200)), 32'hA1B2);
    check("t5_mem1", 32'(mem_rd(20'h00201)), 32'hC3D4);
    check("t5_words", 32'(o_words_written), 32'd2);
    check("t5_idle", 32'(o_busy), 32'd0);

    // T6: reset during the write pulse
    exp_q.push_back('{20'h00300, 16'hBEEF});
    start_job(20'h00300, 20'd1);
    bq = '{8'hBE, 8'hEF};
    send_bytes(bq, 1'b0);
    n = 0;
    while (o_sram_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_pulse", 32'(o_sram_we_n), 32'd0);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_strobes", {o_sram_we_n, o_sram_ce_n, o_bus_own, o_busy}, 4'b1100);
    check("t6_rst_data_z", 32'(sram_data === 16'hzzzz), 32'd1);
    check("t6_rst_words", 32'(o_words_written), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    exp_q.delete();

`ifdef SRAM_WRITE_VERIFY_EN
    // T7: corrupted readback raises o_error, next start clears it
    flip = 16'h0004;
    exp_q.push_back('{20'h00400, 16'h1234});
    start_job(20'h00400, 20'd1);
    bq = '{8'h12, 8'h34};
    send_bytes(bq, 1'b0);
    wait_done();
    check("t7_error_set", 32'(o_error), 32'd1);
    flip = 16'h0000;
    start_job(20'h00000, 20'd0);
    check("t7_error_clear", 32'(o_error), 32'd0);
    repeat (2) @(negedge clk);
`else
    check("oe_never_low", oe_cnt, 0);
`endif

    check("data_z_when_not_owned", z_viol, 0);
    check("addr_data_stable", stab_viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
